// File: rtl/arbiter_client.sv
// rtl/arbiter_client.sv - requester-side burst client for the round-robin arbiter
module arbiter_client #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  request,
  input  logic                  grant,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] remaining, remaining_next;
  logic                 request_next;
  logic                 error_next;
  logic                 beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      request   <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      request   <= request_next;
      error     <= error_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    request_next   = request;
    error_next     = 1'b0;
    cmd_ready      = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    beat           = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) begin
          remaining_next = cmd_len;
          request_next   = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        if (grant) state_next = XFER;
      end
      XFER: begin
        out_valid  = in_valid & grant;
        in_ready   = out_ready & grant;
        beat       = out_valid & out_ready;
        error_next = !grant;
        // The last beat leaves XFER, so remaining is never decremented past zero.
        if (beat) begin
          if (remaining == '0) begin
            request_next = 1'b0;
            state_next   = RELEASE;
          end else begin
            remaining_next = remaining - LEN_ONE;
          end
        end
      end
      RELEASE: begin
        if (!grant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data = in_data;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_arbiter_client.sv
// tb/tb_arbiter_client.sv - self-checking bench for arbiter_client with a 2-port round-robin arbiter model
module tb_arbiter_client;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_cmd_len, b_cmd_len;
  logic        a_cmd_valid, b_cmd_valid, a_cmd_ready, b_cmd_ready;
  logic [31:0] a_in_data, b_in_data, a_out_data, b_out_data;
  logic        a_in_valid, b_in_valid, a_in_ready, b_in_ready;
  logic        a_out_valid, b_out_valid, a_out_ready, b_out_ready;
  logic        a_request, b_request, a_grant, b_grant;
  logic        a_busy, b_busy, a_error, b_error;
  logic        drop_a;

  logic [1:0]  arb_gnt;
  logic        arb_last;

  int checks = 0;
  int failures = 0;

  int r_beats, r_first, r_last, r_req1, r_req_fall, r_rdy_back, r_acc_ready;
  int r_viol, r_dat_err, r_err, r_err_first, r_err_last, r_gap_beats, r_drop_start;

  always #5 clk = ~clk;

  arbiter_client #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .cmd_len(a_cmd_len), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .request(a_request), .grant(a_grant), .busy(a_busy), .error(a_error)
  );

  arbiter_client #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .cmd_len(b_cmd_len), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .request(b_request), .grant(b_grant), .busy(b_busy), .error(b_error)
  );

  // Round-robin arbiter: registered grant, held while the holder keeps requesting.
  always @(posedge clk) begin
    if (rst) begin
      arb_gnt  <= 2'b00;
      arb_last <= 1'b1;
    end else if ((arb_gnt & {b_request, a_request}) != 2'b00) begin
      arb_gnt <= arb_gnt;
    end else if (a_request && b_request) begin
      arb_gnt  <= arb_last ? 2'b01 : 2'b10;
      arb_last <= ~arb_last;
    end else if (a_request) begin
      arb_gnt  <= 2'b01;
      arb_last <= 1'b0;
    end else if (b_request) begin
      arb_gnt  <= 2'b10;
      arb_last <= 1'b1;
    end else begin
      arb_gnt <= 2'b00;
    end
  end

  assign a_grant = arb_gnt[0] & ~drop_a;
  assign b_grant = arb_gnt[1];

  // Drives one burst on client A; r counts cycles after the command-accept edge.
  task automatic run_a(input int len, input int pv, input int pr, input int drop_after);
    logic [31:0] offered[$];
    logic [31:0] pend;
    int  r = 0;
    int  drop_left = 0;
    bit  dropped = 0;
    bit  done = 0;
    r_beats = 0; r_first = -1; r_last = -1; r_req1 = -1; r_req_fall = -1; r_rdy_back = -1;
    r_viol = 0; r_dat_err = 0; r_err = 0; r_err_first = -1; r_err_last = -1;
    r_gap_beats = 0; r_drop_start = -1;
    pend = $urandom;
    offered.push_back(pend);
    a_cmd_len = len[7:0]; a_cmd_valid = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = pend;
    @(negedge clk);
    r_acc_ready = a_cmd_ready;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    while (!done && r < 600) begin
      r++;
      drop_a = (drop_left > 0);
      if (drop_left > 0) begin
        if (r_drop_start < 0) r_drop_start = r;
        drop_left--;
      end
      a_in_valid  = ($urandom_range(99) < pv);
      a_out_ready = (pr < 0) ? r[0] : ($urandom_range(99) < pr);
      a_in_data   = pend;
      @(negedge clk);
      if (r == 1) r_req1 = a_request;
      if (a_out_valid && !(a_in_valid && a_grant)) r_viol++;
      if (a_in_ready && !(a_out_ready && a_grant)) r_viol++;
      if (a_error) begin
        r_err++;
        if (r_err_first < 0) r_err_first = r;
        r_err_last = r;
      end
      if (a_out_valid && a_out_ready) begin
        if (a_out_data !== offered[r_beats]) r_dat_err++;
        if (drop_a) r_gap_beats++;
        if (r_first < 0) r_first = r;
        r_last = r;
        r_beats++;
        pend = $urandom;
        offered.push_back(pend);
      end
      if (drop_after >= 0 && !dropped && r_beats == drop_after) begin
        drop_left = 2;
        dropped = 1;
      end
      if (r_beats > 0 && r_req_fall < 0 && !a_request) r_req_fall = r;
      if (r_req_fall >= 0 && a_cmd_ready) begin
        r_rdy_back = r;
        done = 1;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0; drop_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (a_cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready_in_rst got=%b exp=0", a_cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_request !== 1'b0) begin failures++; $display("FAIL reset_request got=%b exp=0", a_request); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    checks++; if (a_error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", a_error); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
    checks++; if (a_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", a_cmd_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
  endtask

  task automatic test_single();
    run_a(3, 100, 100, -1);
    checks++; if (r_acc_ready !== 1) begin failures++; $display("FAIL single_accept got=%0d exp=1", r_acc_ready); end
    checks++; if (r_req1 !== 1) begin failures++; $display("FAIL single_request_t1 got=%0d exp=1", r_req1); end
    checks++; if (r_first !== 3) begin failures++; $display("FAIL single_first_beat got=%0d exp=3", r_first); end
    checks++; if (r_beats !== 4) begin failures++; $display("FAIL single_beats got=%0d exp=4", r_beats); end
    checks++; if (r_last !== 6) begin failures++; $display("FAIL single_last_beat got=%0d exp=6", r_last); end
    checks++; if (r_req_fall !== 7) begin failures++; $display("FAIL single_req_fall got=%0d exp=7", r_req_fall); end
    checks++; if (r_rdy_back !== 9) begin failures++; $display("FAIL single_cmd_ready_back got=%0d exp=9", r_rdy_back); end
    checks++; if (r_dat_err !== 0) begin failures++; $display("FAIL single_data got=%0d errors exp=0", r_dat_err); end
  endtask

  task automatic test_min_max();
    run_a(0, 100, 100, -1);
    checks++; if (r_beats !== 1) begin failures++; $display("FAIL min_beats got=%0d exp=1", r_beats); end
    checks++; if (r_req_fall !== 4) begin failures++; $display("FAIL min_req_fall got=%0d exp=4", r_req_fall); end
    checks++; if (r_rdy_back !== 6) begin failures++; $display("FAIL min_cmd_ready_back got=%0d exp=6", r_rdy_back); end
    run_a(255, 100, 100, -1);
    checks++; if (r_beats !== 256) begin failures++; $display("FAIL max_beats got=%0d exp=256", r_beats); end
    checks++; if (r_last !== 258) begin failures++; $display("FAIL max_last_beat got=%0d exp=258", r_last); end
    checks++; if (r_rdy_back !== 261) begin failures++; $display("FAIL max_cmd_ready_back got=%0d exp=261", r_rdy_back); end
    checks++; if (r_dat_err !== 0) begin failures++; $display("FAIL max_data got=%0d errors exp=0", r_dat_err); end
  endtask

  task automatic test_backpressure();
    run_a(4, 60, -1, -1);
    checks++; if (r_beats !== 5) begin failures++; $display("FAIL bp_beats got=%0d exp=5", r_beats); end
    checks++; if (r_dat_err !== 0) begin failures++; $display("FAIL bp_data_order got=%0d errors exp=0", r_dat_err); end
    checks++; if (r_viol !== 0) begin failures++; $display("FAIL bp_handshake got=%0d violations exp=0", r_viol); end
    checks++; if (r_rdy_back !== r_last + 3) begin failures++; $display("FAIL bp_cmd_ready_back got=%0d exp=%0d", r_rdy_back, r_last + 3); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int len;
      int pv;
      int pr;
      len = $urandom_range(12, 0);
      pv  = $urandom_range(100, 30);
      pr  = $urandom_range(100, 30);
      run_a(len, pv, pr, -1);
      checks++; if (r_beats !== len + 1) begin failures++; $display("FAIL rand%0d_beats got=%0d exp=%0d", i, r_beats, len + 1); end
      checks++; if (r_dat_err !== 0) begin failures++; $display("FAIL rand%0d_data got=%0d errors exp=0", i, r_dat_err); end
      checks++; if (r_viol !== 0) begin failures++; $display("FAIL rand%0d_handshake got=%0d violations exp=0", i, r_viol); end
      checks++; if (r_err !== 0) begin failures++; $display("FAIL rand%0d_error got=%0d pulses exp=0", i, r_err); end
      checks++; if (r_req_fall !== r_last + 1) begin failures++; $display("FAIL rand%0d_req_fall got=%0d exp=%0d", i, r_req_fall, r_last + 1); end
    end
  endtask

  task automatic test_grant_lost();
    run_a(5, 100, 100, 2);
    checks++; if (r_beats !== 6) begin failures++; $display("FAIL glost_beats got=%0d exp=6", r_beats); end
    checks++; if (r_err !== 2) begin failures++; $display("FAIL glost_error_pulses got=%0d exp=2", r_err); end
    checks++; if (r_err_first !== r_drop_start + 1) begin failures++; $display("FAIL glost_error_start got=%0d exp=%0d", r_err_first, r_drop_start + 1); end
    checks++; if (r_err_last !== r_err_first + 1) begin failures++; $display("FAIL glost_error_end got=%0d exp=%0d", r_err_last, r_err_first + 1); end
    checks++; if (r_gap_beats !== 0) begin failures++; $display("FAIL glost_gap_beats got=%0d exp=0", r_gap_beats); end
    checks++; if (r_dat_err !== 0) begin failures++; $display("FAIL glost_data got=%0d errors exp=0", r_dat_err); end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int r = 0;
    a_cmd_len = 8'd5; a_cmd_valid = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_data = $urandom;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    while (beats < 2 && r < 20) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) beats++;
      r++;
      @(posedge clk); #1;
    end
    rst = 1'b1; a_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_cmd_ready !== 1'b0) begin failures++; $display("FAIL rmid_cmd_ready_in_rst got=%b exp=0", a_cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    checks++; if (a_request !== 1'b0) begin failures++; $display("FAIL rmid_request got=%b exp=0", a_request); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", a_busy); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", a_out_valid); end
    beats = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (a_out_valid && a_out_ready) beats++;
    end
    checks++; if (beats !== 0) begin failures++; $display("FAIL rmid_stray_beats got=%0d exp=0", beats); end
    @(posedge clk); #1;
    run_a(2, 100, 100, -1);
    checks++; if (r_beats !== 3) begin failures++; $display("FAIL rmid_next_burst_beats got=%0d exp=3", r_beats); end
  endtask

  task automatic test_fairness();
    int acc_a = 0;
    int acc_b = 0;
    int idle_gnt = 0;
    int cyc = 0;
    int runs = 0;
    int bad_runs = 0;
    int a_runs = 0;
    int run_len = 0;
    int owner_q[$];
    a_in_valid = 1'b1; a_out_ready = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
    a_cmd_len = 8'd1; b_cmd_len = 8'd1; a_cmd_valid = 1'b1; b_cmd_valid = 1'b1;
    while (!(owner_q.size() >= 16 && !a_busy && !b_busy) && cyc < 300) begin
      @(negedge clk);
      if (a_cmd_valid && a_cmd_ready) acc_a++;
      if (b_cmd_valid && b_cmd_ready) acc_b++;
      if (a_out_valid && a_out_ready) owner_q.push_back(0);
      if (b_out_valid && b_out_ready) owner_q.push_back(1);
      if (a_grant && !a_busy) idle_gnt++;
      if (b_grant && !b_busy) idle_gnt++;
      @(posedge clk); #1;
      a_cmd_valid = (acc_a < 4); b_cmd_valid = (acc_b < 4);
      a_in_data = $urandom; b_in_data = $urandom;
      cyc++;
    end
    a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b0; b_out_ready = 1'b0;
    for (int i = 0; i < owner_q.size(); i++) begin
      run_len++;
      if (i == owner_q.size() - 1 || owner_q[i + 1] != owner_q[i]) begin
        runs++;
        if (owner_q[i] == 0) a_runs++;
        if (run_len != 2) bad_runs++;
        run_len = 0;
      end
    end
    checks++; if (owner_q.size() !== 16) begin failures++; $display("FAIL fair_total_beats got=%0d exp=16", owner_q.size()); end
    checks++; if (runs !== 8) begin failures++; $display("FAIL fair_alternations got=%0d runs exp=8", runs); end
    checks++; if (bad_runs !== 0) begin failures++; $display("FAIL fair_split_bursts got=%0d exp=0", bad_runs); end
    checks++; if (a_runs !== 4) begin failures++; $display("FAIL fair_a_bursts got=%0d exp=4", a_runs); end
    checks++; if (idle_gnt !== 0) begin failures++; $display("FAIL fair_grant_in_idle got=%0d exp=0", idle_gnt); end
  endtask

  initial begin
    rst = 1'b1; drop_a = 1'b0;
    a_cmd_len = '0; a_cmd_valid = 1'b0; a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_cmd_len = '0; b_cmd_valid = 1'b0; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_single();
    test_min_max();
    test_backpressure();
    test_random();
    test_grant_lost();
    test_reset_mid();
    test_fairness();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbiter_client.md
# arbiter_client

Requester-side companion to the round-robin arbiter: one instance sits between a single actor and one bit of the arbiter's `request`/`grant` vectors.

- Accepts burst commands from the actor and raises `request`.
- Waits for `grant`, then streams exactly `cmd_len+1` data beats to the shared resource.
- Drops `request` and holds it low until `grant` falls, which hands the token to the next requester.
- This keeps per-burst ownership fair under the arbiter's hold-while-requested policy.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of data beats
- `LEN_WIDTH`, 8, width of burst length field; burst = `cmd_len+1` beats (1..2^LEN_WIDTH)

Ports:
- `clk`  in  1  clock; all logic on rising edge; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `cmd_len`  in  LEN_WIDTH  beats minus one for the next burst
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `in_data`  in  DATA_WIDTH  actor data
- `in_valid`  in  1  actor data valid
- `in_ready`  out  1  actor beat consumed when `in_valid & in_ready`
- `out_data`  out  DATA_WIDTH  data to shared resource (= `in_data`, combinational)
- `out_valid`  out  1  beat offered to shared resource
- `out_ready`  in  1  shared resource accepts beat
- `request`  out  1  registered; drives this port's arbiter request bit
- `grant`  in  1  this port's arbiter grant bit (registered by the arbiter)
- `busy`  out  1  high in any state other than IDLE
- `error`  out  1  registered one-cycle pulse: `grant` seen low during XFER

## Operation
States: IDLE, REQ, XFER, RELEASE.

- **IDLE**
  - `cmd_ready=1`.
  - On `cmd_valid`: latch `remaining <= cmd_len`, `request <= 1`, go to REQ.
  - `grant` is ignored in IDLE.
- **REQ**
  - `request=1`; no beats move.
  - On `grant=1`: go to XFER.
- **XFER**
  - `request=1`.
  - `out_valid = in_valid & grant`; `in_ready = out_ready & grant`.
  - A beat transfers when `out_valid & out_ready`. On each beat: `remaining <= remaining-1`.
  - On the beat with `remaining==0`: `request <= 0`, go to RELEASE.
  - If `grant=0` in XFER: no beats, `error` pulses next cycle, state holds.
- **RELEASE**
  - `request=0`; `out_valid=0`, `in_ready=0`.
  - On `grant=0`: go to IDLE.
- Outputs outside XFER: `out_valid=0`, `in_ready=0`.
- `cmd_ready=0` outside IDLE and during `rst`.
- `remaining` is exactly LEN_WIDTH bits. It never underflows because the last beat exits XFER.
- `cmd_len=0` gives a single beat; `cmd_len=2^LEN_WIDTH-1` gives 2^LEN_WIDTH beats.
- Reset values: state IDLE, `request=0`, `error=0`, `remaining=0`, `busy=0`, `out_valid=0`, `in_ready=0`.
  - Reset mid-burst drops `request` next cycle; the burst is abandoned with no further beats.

## Timing
- **Command accept.** Command accepted at edge t → `request=1` in cycle t+1.
- **Grant response.** Arbiter grant arrives no earlier than cycle t+2 (uncontended: t+2).
  - XFER is entered the cycle after `grant` is first seen.
  - First beat possible in cycle t+3 when uncontended.
- **Release.** Last beat in cycle n → `request=0` in n+1.
  - `grant` is still 1 in n+1, because the arbiter registered request=1 from cycle n; it is ignored there.
  - `grant=0` in n+2 → IDLE in n+3, `cmd_ready=1` in n+3.
  - `request` is therefore low for at least 2 cycles between bursts. This guarantees the token advances if any other port requests.
- **Backpressure.** `out_ready` or `in_valid` low stalls the counter; there is no time limit in XFER.
- **Simultaneous events.** A beat and `grant` falling in the same cycle is impossible: grant is the value registered one cycle earlier and is used as-is; no beat without `grant=1`.

## Test plan
- **Single uncontended burst.** Reset, then `cmd_len=3`, arbiter grants immediately, `in_valid`/`out_ready` held 1 → exactly 4 beats on consecutive cycles, then `request` falls the cycle after the 4th beat and `cmd_ready` returns 2 cycles later.
- **Minimum burst.** `cmd_len=0` → exactly 1 beat. `cmd_len=255` (LEN_WIDTH=8) → exactly 256 beats; the counter does not wrap early.
- **Backpressure.** `cmd_len=4`, `out_ready` toggling 1,0,1,0… and `in_valid` gaps → 5 beats transferred, data order preserved, no beat while either is low.
- **Fairness with real arbiter.** Two clients on a 2-port arbiter, each with back-to-back `cmd_len=1` commands → grants alternate per burst (A,B,A,B), no burst is split, and a port's `grant` is never high while its client is in IDLE.
- **Reset mid-XFER.** Assert `rst` after 2 of 6 beats → next cycle `request=0`, `busy=0`, `out_valid=0`. A new `cmd_len=2` after reset transfers exactly 3 beats.
- **Grant lost.** Force `grant=0` for 2 cycles mid-XFER → `error` pulses for exactly 2 cycles, no beats during the gap, and the burst completes with the correct total once `grant` returns.
